lii_stream_pack_wrapper: RTL and testbench



---
 rtl/lii_pkg.sv | 30 +++
 rtl/lii_sync_fifo.sv | 48 ++++
 rtl/lii_stream_pack_wrapper.sv | 154 +++++++++++++++
 tb/tb_lii_stream_pack_wrapper.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lii_pkg.sv
// Shared LII constants, tag payload type and helpers for packed per-stream width vectors.
package lii_pkg;

    localparam int unsigned LII_TAG_W       = 8;
    localparam int unsigned LII_MAX_STREAMS = 8;
    localparam int unsigned LII_WFIELD_W    = 16;
    localparam int unsigned LII_WVEC_W      = LII_MAX_STREAMS * LII_WFIELD_W;

    typedef struct packed {
        logic [LII_TAG_W-1:0] src;
        logic [LII_TAG_W-1:0] dst;
    } lii_tag_t;

    // Bit offset of stream idx: sum of the widths of all lower-indexed streams.
    function automatic int unsigned width_offset(input logic [LII_WVEC_W-1:0] vec,
                                                 input int unsigned idx);
        int unsigned acc;
        acc = 0;
        for (int unsigned k = 0; k < LII_MAX_STREAMS; k++) begin
            if (k < idx) acc = acc + 32'(vec[k*LII_WFIELD_W +: LII_WFIELD_W]);
        end
        return acc;
    endfunction

    function automatic int unsigned width_at(input logic [LII_WVEC_W-1:0] vec,
                                             input int unsigned idx);
        return 32'(vec[idx*LII_WFIELD_W +: LII_WFIELD_W]);
    endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry a wrap bit so full/empty need no counter.
module lii_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_c,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_i && !empty_c) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_i && !full_c) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/lii_stream_pack_wrapper.sv
// LII phy<->kernel adapter: unpacks phy words into per-stream FIFOs, packs kernel beats into phy words.
// Optional LII_DST_FILTER_EN: discard input words whose dst tag differs from NODE_ID and count them.
module lii_stream_pack_wrapper
    import lii_pkg::*;
#(
    parameter int unsigned                      NIN        = 2,
    parameter int unsigned                      NOUT       = 1,
    parameter int unsigned                      PW         = 128,
    parameter logic [NIN*LII_WFIELD_W-1:0]      IN_WIDTHS  = {16'd58, 16'd56},
    parameter logic [NOUT*LII_WFIELD_W-1:0]     OUT_WIDTHS = {16'd32},
    parameter int unsigned                      DEPTH      = 4,
    parameter logic [LII_TAG_W-1:0]             SRC_ID     = 8'h00,
    parameter logic [LII_TAG_W-1:0]             DST_ID     = 8'h00,
    parameter logic [LII_TAG_W-1:0]             NODE_ID    = 8'h00
) (
    input  logic                  aclk,
    input  logic                  arstn,
    input  logic [PW-1:0]         lii_in_p0_tdata,
    input  logic                  lii_in_p0_tvalid,
    output logic                  lii_in_p0_tready,
    input  logic [LII_TAG_W-1:0]  lii_in_p0_src,
    input  logic [LII_TAG_W-1:0]  lii_in_p0_dst,
    output logic [PW-1:0]         lii_out_p0_tdata,
    output logic                  lii_out_p0_tvalid,
    input  logic                  lii_out_p0_tready,
    output logic [LII_TAG_W-1:0]  lii_out_p0_src,
    output logic [LII_TAG_W-1:0]  lii_out_p0_dst,
    output logic [width_offset(LII_WVEC_W'(IN_WIDTHS), NIN)-1:0]   k_in_tdata,
    output logic [NIN-1:0]        k_in_tvalid,
    input  logic [NIN-1:0]        k_in_tready,
    input  logic [width_offset(LII_WVEC_W'(OUT_WIDTHS), NOUT)-1:0] k_out_tdata,
    input  logic [NOUT-1:0]       k_out_tvalid,
    output logic [NOUT-1:0]       k_out_tready,
    output logic                  ce,
    output logic [15:0]           drop_count
);

    localparam logic [LII_WVEC_W-1:0] IN_VEC  = LII_WVEC_W'(IN_WIDTHS);
    localparam logic [LII_WVEC_W-1:0] OUT_VEC = LII_WVEC_W'(OUT_WIDTHS);
    localparam int unsigned IN_TOT  = width_offset(IN_VEC, NIN);
    localparam int unsigned OUT_TOT = width_offset(OUT_VEC, NOUT);

    if (IN_TOT > PW || OUT_TOT > PW) begin : g_width_check
        $error("lii_stream_pack_wrapper: summed stream widths exceed PW");
    end

    logic               run_q;
    logic [NIN-1:0]     fifo_full;
    logic [NIN-1:0]     fifo_empty;
    logic [NIN-1:0]     fifo_pop;
    logic               in_push;
    logic               fire;
    logic [NOUT-1:0]    slot_full_q, slot_full_d, slot_accept;
    logic [OUT_TOT-1:0] slot_data_q, slot_data_d;
    lii_tag_t           out_tag;

    // Holds every ready/ce low until the first edge after reset release.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

`ifdef LII_DST_FILTER_EN
    logic        dst_miss;
    logic [15:0] drop_q, drop_d;
    logic        unused_src;

    assign dst_miss         = (lii_in_p0_dst != NODE_ID);
    assign lii_in_p0_tready = run_q && (dst_miss || !(|fifo_full));
    assign in_push          = lii_in_p0_tvalid && lii_in_p0_tready && !dst_miss;

    always_comb begin
        drop_d = drop_q;
        if (lii_in_p0_tvalid && lii_in_p0_tready && dst_miss && (drop_q != 16'hFFFF))
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_count = drop_q;
    assign unused_src = ^lii_in_p0_src;
`else
    logic unused_tags;

    assign lii_in_p0_tready = run_q && !(|fifo_full);
    assign in_push          = lii_in_p0_tvalid && lii_in_p0_tready;
    assign drop_count       = '0;
    assign unused_tags      = ^{lii_in_p0_src, lii_in_p0_dst, NODE_ID};
`endif

    if (IN_TOT < PW) begin : g_in_hi
        logic unused_hi;
        assign unused_hi = ^lii_in_p0_tdata[PW-1:IN_TOT];
    end

    // Every stream pushes its slice together; each drains on its own ready.
    for (genvar i = 0; i < NIN; i++) begin : g_in
        localparam int unsigned OFF = width_offset(IN_VEC, i);
        localparam int unsigned WI  = width_at(IN_VEC, i);

        lii_sync_fifo #(.W(WI), .DEPTH(DEPTH)) u_fifo (
            .clk     (aclk),
            .rst_n   (arstn),
            .push_i  (in_push),
            .wdata_i (lii_in_p0_tdata[OFF +: WI]),
            .pop_i   (fifo_pop[i]),
            .rdata_c (k_in_tdata[OFF +: WI]),
            .full_c  (fifo_full[i]),
            .empty_c (fifo_empty[i])
        );

        assign fifo_pop[i] = !fifo_empty[i] && k_in_tready[i];
    end

    assign k_in_tvalid = ~fifo_empty;

    // A slot can refill in the very cycle the packed word leaves.
    assign fire         = lii_out_p0_tvalid && lii_out_p0_tready;
    assign k_out_tready = run_q ? (~slot_full_q | {NOUT{fire}}) : '0;
    assign slot_accept  = k_out_tvalid & k_out_tready;
    assign slot_full_d  = (slot_full_q & ~{NOUT{fire}}) | slot_accept;

    for (genvar j = 0; j < NOUT; j++) begin : g_out
        localparam int unsigned OFF = width_offset(OUT_VEC, j);
        localparam int unsigned WJ  = width_at(OUT_VEC, j);

        assign slot_data_d[OFF +: WJ] = slot_accept[j] ? k_out_tdata[OFF +: WJ]
                                                       : slot_data_q[OFF +: WJ];
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            slot_full_q <= '0;
            slot_data_q <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            slot_data_q <= slot_data_d;
        end
    end

    assign lii_out_p0_tvalid = &slot_full_q;
    assign lii_out_p0_tdata  = PW'(slot_data_q);

    assign out_tag        = '{src: SRC_ID, dst: DST_ID};
    assign lii_out_p0_src = out_tag.src;
    assign lii_out_p0_dst = out_tag.dst;

    // Stall the kernel when an output slot is blocked or when it has nothing to chew on.
    assign ce = run_q && (&k_out_tready) && ((|k_in_tvalid) || !(|slot_full_q));

endmodule

// File: tb/tb_lii_stream_pack_wrapper.sv
// Randomised and directed bench for lii_stream_pack_wrapper against a queue-based reference model.
module tb_lii_stream_pack_wrapper;

    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  NODE  = 8'h05;
    localparam logic [7:0]  SRC   = 8'h3C;
    localparam logic [7:0]  DSTT  = 8'hA7;

    logic         aclk = 1'b0;
    logic         arstn = 1'b1;
    logic [127:0] lii_in_p0_tdata = '0;
    logic         lii_in_p0_tvalid = 1'b0;
    logic         lii_in_p0_tready;
    logic [7:0]   lii_in_p0_src = '0;
    logic [7:0]   lii_in_p0_dst = '0;
    logic [127:0] lii_out_p0_tdata;
    logic         lii_out_p0_tvalid;
    logic         lii_out_p0_tready = 1'b0;
    logic [7:0]   lii_out_p0_src;
    logic [7:0]   lii_out_p0_dst;
    logic [113:0] k_in_tdata;
    logic [1:0]   k_in_tvalid;
    logic [1:0]   k_in_tready = '0;
    logic [31:0]  k_out_tdata = '0;
    logic         k_out_tvalid = 1'b0;
    logic         k_out_tready;
    logic         ce;
    logic [15:0]  drop_count;

    lii_stream_pack_wrapper #(
        .NIN(2), .NOUT(1), .PW(128), .IN_WIDTHS({16'd58, 16'd56}), .OUT_WIDTHS({16'd32}),
        .DEPTH(DEPTH), .SRC_ID(SRC), .DST_ID(DSTT), .NODE_ID(NODE)
    ) dut (
        .aclk(aclk), .arstn(arstn),
        .lii_in_p0_tdata(lii_in_p0_tdata), .lii_in_p0_tvalid(lii_in_p0_tvalid),
        .lii_in_p0_tready(lii_in_p0_tready), .lii_in_p0_src(lii_in_p0_src),
        .lii_in_p0_dst(lii_in_p0_dst),
        .lii_out_p0_tdata(lii_out_p0_tdata), .lii_out_p0_tvalid(lii_out_p0_tvalid),
        .lii_out_p0_tready(lii_out_p0_tready), .lii_out_p0_src(lii_out_p0_src),
        .lii_out_p0_dst(lii_out_p0_dst),
        .k_in_tdata(k_in_tdata), .k_in_tvalid(k_in_tvalid), .k_in_tready(k_in_tready),
        .k_out_tdata(k_out_tdata), .k_out_tvalid(k_out_tvalid), .k_out_tready(k_out_tready),
        .ce(ce), .drop_count(drop_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per input stream, one optional value per output slot.
    logic [55:0]  q0[$];
    logic [57:0]  q1[$];
    bit           slot_vld = 1'b0;
    logic [31:0]  slot_val = '0;
    bit           run = 1'b0;
    int unsigned  drops = 0;

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs at negedge, compare against the model, advance the model at posedge.
    task automatic step(input bit tv, input logic [127:0] td, input logic [7:0] dst,
                        input logic [1:0] kir, input bit kov, input logic [31:0] kod,
                        input bit otr);
        bit         exp_rdy, exp_fire, exp_kor, exp_ce, push_ok;
        logic [1:0] exp_kiv;
        @(negedge aclk);
        lii_in_p0_tvalid  = tv;
        lii_in_p0_tdata   = td;
        lii_in_p0_dst     = dst;
        lii_in_p0_src     = td[7:0];
        k_in_tready       = kir;
        k_out_tvalid      = kov;
        k_out_tdata       = kod;
        lii_out_p0_tready = otr;
        #1;
        exp_kiv  = {q1.size() != 0, q0.size() != 0};
        exp_rdy  = run && (q0.size() < DEPTH) && (q1.size() < DEPTH);
`ifdef LII_DST_FILTER_EN
        if (dst != NODE) exp_rdy = run;
`endif
        exp_fire = slot_vld && otr;
        exp_kor  = run && (!slot_vld || exp_fire);
        exp_ce   = run && exp_kor && ((exp_kiv != 2'b00) || !slot_vld);

        checks++; if (lii_in_p0_tready !== exp_rdy) begin errors++;
            $display("FAIL in_tready: got %b exp %b t=%0t", lii_in_p0_tready, exp_rdy, $time); end
        checks++; if (k_in_tvalid !== exp_kiv) begin errors++;
            $display("FAIL k_in_tvalid: got %b exp %b t=%0t", k_in_tvalid, exp_kiv, $time); end
        if (exp_kiv[0]) begin
            checks++; if (k_in_tdata[55:0] !== q0[0]) begin errors++;
                $display("FAIL k_in_data0: got %h exp %h t=%0t", k_in_tdata[55:0], q0[0], $time); end
        end
        if (exp_kiv[1]) begin
            checks++; if (k_in_tdata[113:56] !== q1[0]) begin errors++;
                $display("FAIL k_in_data1: got %h exp %h t=%0t", k_in_tdata[113:56], q1[0], $time); end
        end
        checks++; if (lii_out_p0_tvalid !== slot_vld) begin errors++;
            $display("FAIL out_tvalid: got %b exp %b t=%0t", lii_out_p0_tvalid, slot_vld, $time); end
        if (slot_vld) begin
            checks++; if (lii_out_p0_tdata !== {96'h0, slot_val}) begin errors++;
                $display("FAIL out_tdata: got %h exp %h t=%0t", lii_out_p0_tdata, {96'h0, slot_val}, $time); end
        end
        checks++; if (k_out_tready !== exp_kor) begin errors++;
            $display("FAIL k_out_tready: got %b exp %b t=%0t", k_out_tready, exp_kor, $time); end
        checks++; if (ce !== exp_ce) begin errors++;
            $display("FAIL ce: got %b exp %b t=%0t", ce, exp_ce, $time); end
        checks++; if (drop_count !== 16'(drops)) begin errors++;
            $display("FAIL drop_count: got %0d exp %0d t=%0t", drop_count, drops, $time); end

        @(posedge aclk);
        if (exp_kiv[0] && kir[0]) void'(q0.pop_front());
        if (exp_kiv[1] && kir[1]) void'(q1.pop_front());
        push_ok = tv && exp_rdy;
`ifdef LII_DST_FILTER_EN
        if (dst != NODE) begin
            if (push_ok && drops < 32'hFFFF) drops++;
            push_ok = 1'b0;
        end
`endif
        if (push_ok) begin
            q0.push_back(td[55:0]);
            q1.push_back(td[113:56]);
        end
        if (exp_fire) slot_vld = 1'b0;
        if (kov && exp_kor) begin
            slot_vld = 1'b1;
            slot_val = kod;
        end
    endtask

    task automatic idle(input logic [1:0] kir, input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, NODE, kir, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        arstn = 1'b0;
        lii_in_p0_tvalid = 1'b0; lii_in_p0_dst = '0; k_in_tready = '0;
        k_out_tvalid = 1'b0; lii_out_p0_tready = 1'b0;
        q0.delete(); q1.delete(); slot_vld = 1'b0; run = 1'b0; drops = 0;
        #1;
        checks++; if (lii_in_p0_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b exp 0", lii_in_p0_tready); end
        checks++; if (k_in_tvalid !== 2'b00) begin errors++; $display("FAIL rst_k_in_tvalid: got %b exp 00", k_in_tvalid); end
        checks++; if (lii_out_p0_tvalid !== 1'b0) begin errors++; $display("FAIL rst_out_tvalid: got %b exp 0", lii_out_p0_tvalid); end
        checks++; if (k_out_tready !== 1'b0) begin errors++; $display("FAIL rst_k_out_tready: got %b exp 0", k_out_tready); end
        checks++; if (ce !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b exp 0", ce); end
        checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL rst_drop: got %0d exp 0", drop_count); end
        @(negedge aclk);
        arstn = 1'b1;
        @(posedge aclk);
        #1;
        run = 1'b1;
        checks++; if (lii_in_p0_tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready: got %b exp 1", lii_in_p0_tready); end
        checks++; if (ce !== 1'b1) begin errors++; $display("FAIL post_rst_ce: got %b exp 1", ce); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (lii_out_p0_src !== SRC) begin errors++; $display("FAIL tag_src: got %h exp %h", lii_out_p0_src, SRC); end
        checks++; if (lii_out_p0_dst !== DSTT) begin errors++; $display("FAIL tag_dst: got %h exp %h", lii_out_p0_dst, DSTT); end
    endtask

    task automatic test_slice();
        logic [127:0] w;
        w = {14'h2D5B, 58'h3_1234_5678_9ABC_FF, 56'hA5_5AC3_3C0F_F001};
        step(1'b1, w, NODE, 2'b00, 1'b0, '0, 1'b0);
        #1;
        checks++; if (k_in_tdata[55:0] !== 56'hA5_5AC3_3C0F_F001) begin errors++;
            $display("FAIL slice0: got %h exp a55ac33c0ff001", k_in_tdata[55:0]); end
        checks++; if (k_in_tdata[113:56] !== 58'h3_1234_5678_9ABC_FF) begin errors++;
            $display("FAIL slice1: got %h exp 3123456789abcff", k_in_tdata[113:56]); end
        idle(2'b11, 2);
    endtask

    task automatic test_independent_drain();
        for (int k = 0; k < 4; k++) step(1'b1, rand_word(), NODE, 2'b00, 1'b0, '0, 1'b0);
        #1;
        checks++; if (lii_in_p0_tready !== 1'b0) begin errors++; $display("FAIL drain_full_tready: got %b exp 0", lii_in_p0_tready); end
        idle(2'b01, 4);
        #1;
        checks++; if (k_in_tvalid !== 2'b10) begin errors++; $display("FAIL drain_tvalid: got %b exp 10", k_in_tvalid); end
        checks++; if (lii_in_p0_tready !== 1'b0) begin errors++; $display("FAIL drain_hold_tready: got %b exp 0", lii_in_p0_tready); end
        idle(2'b10, 1);
        #1;
        checks++; if (lii_in_p0_tready !== 1'b1) begin errors++; $display("FAIL drain_pulse_tready: got %b exp 1", lii_in_p0_tready); end
        idle(2'b11, 4);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) step(1'b1, rand_word(), NODE, 2'b10, 1'b0, '0, 1'b0);
        #1;
        checks++; if (k_in_tvalid[0] !== 1'b1) begin errors++; $display("FAIL mid_fill: got %b exp 1", k_in_tvalid[0]); end
        do_reset();
    endtask

    task automatic test_backpressure();
        step(1'b0, '0, NODE, 2'b00, 1'b1, 32'hDEADBEEF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, NODE, 2'b00, 1'b1, $urandom, 1'b0);
            #1;
            checks++; if (lii_out_p0_tvalid !== 1'b1 || lii_out_p0_tdata[31:0] !== 32'hDEADBEEF) begin errors++;
                $display("FAIL bp_hold: got v=%b d=%h exp v=1 d=deadbeef", lii_out_p0_tvalid, lii_out_p0_tdata[31:0]); end
            checks++; if (ce !== 1'b0) begin errors++; $display("FAIL bp_ce: got %b exp 0", ce); end
        end
        step(1'b0, '0, NODE, 2'b00, 1'b1, 32'hCAFEF00D, 1'b1);
        #1;
        checks++; if (lii_out_p0_tvalid !== 1'b1 || lii_out_p0_tdata[31:0] !== 32'hCAFEF00D) begin errors++;
            $display("FAIL bp_refill: got v=%b d=%h exp v=1 d=cafef00d", lii_out_p0_tvalid, lii_out_p0_tdata[31:0]); end
        idle(2'b11, 1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 20; k++) begin
            step(1'b1, rand_word(), NODE, 2'b11, 1'b1, $urandom, 1'b1);
            #1;
            checks++; if (ce !== 1'b1) begin errors++; $display("FAIL b2b_ce: got %b exp 1 cyc=%0d", ce, k); end
            checks++; if (lii_in_p0_tready !== 1'b1 || lii_out_p0_tvalid !== 1'b1 || k_in_tvalid !== 2'b11) begin errors++;
                $display("FAIL b2b_flow: got rdy=%b ov=%b kv=%b exp 1 1 11 cyc=%0d", lii_in_p0_tready, lii_out_p0_tvalid, k_in_tvalid, k); end
        end
        idle(2'b11, 3);
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int k = 0; k < 400; k++) begin
`ifdef LII_DST_FILTER_EN
            d = ($urandom_range(0, 3) == 0) ? 8'h07 : NODE;
`else
            d = 8'($urandom);
`endif
            step($urandom_range(0, 3) != 0, rand_word(), d, 2'($urandom), $urandom_range(0, 2) != 0,
                 $urandom, 1'($urandom));
        end
        idle(2'b11, 6);
    endtask

`ifdef LII_DST_FILTER_EN
    task automatic test_filter();
        logic [7:0] dsts [4];
        dsts = '{8'h05, 8'h07, 8'h07, 8'h05};
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, rand_word(), dsts[k], 2'b00, 1'b0, '0, 1'b0);
        #1;
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL filt_drop: got %0d exp 2", drop_count); end
        idle(2'b01, 2);
        #1;
        checks++; if (k_in_tvalid !== 2'b10) begin errors++; $display("FAIL filt_enq: got %b exp 10", k_in_tvalid); end
        idle(2'b11, 2);
        @(negedge aclk);
        lii_in_p0_tvalid = 1'b1;
        lii_in_p0_dst    = 8'h07;
        repeat (65537) @(posedge aclk);
        @(negedge aclk);
        lii_in_p0_tvalid = 1'b0;
        #1;
        checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL filt_sat: got %h exp ffff", drop_count); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_slice();
        test_independent_drain();
        test_reset_mid();
        test_backpressure();
        test_back_to_back();
        test_random();
`ifdef LII_DST_FILTER_EN
        test_filter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
